// File: rtl/wb_stage_mc.sv
// Write-back stage for the 5-stage core.
// Registered outputs, valid/ready handshake toward MEM, multi-cycle load wait,
// byte-offset load alignment for 32- or 64-bit datapaths, LWL/LWR merging,
// and an LL/SC reservation register.
module wb_stage_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              InValid,
  output logic              InReady,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] DestReg,
  input  logic [3:0]        Memfunc,
  input  logic [DATA_W-1:0] ALUData,
  input  logic [DATA_W-1:0] RtData,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  input  logic              MemValid,
  input  logic              Invalidate,
  output logic              WBValid,
  output logic              WBWrite,
  output logic [REG_AW-1:0] WBReg,
  output logic [DATA_W-1:0] WBData,
  output logic              LLBit
);

  // Byte lanes per data word and the width of the in-word byte offset.
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  // Offset masks: halfword ignores bit0, word ignores bits [1:0].
  localparam logic [OW-1:0]     HALF_MASK = ~(OW'(1));
  localparam logic [OW-1:0]     WORD_MASK = ~(OW'(3));
  localparam logic [DATA_W-1:0] ONES      = '1;

  // Memory function encodings.
  localparam logic [3:0] MF_BS = 4'd0;
  localparam logic [3:0] MF_BU = 4'd1;
  localparam logic [3:0] MF_HS = 4'd2;
  localparam logic [3:0] MF_HU = 4'd3;
  localparam logic [3:0] MF_WD = 4'd4;
  localparam logic [3:0] MF_WL = 4'd5;
  localparam logic [3:0] MF_WR = 4'd6;
  localparam logic [3:0] MF_SC = 4'd7;
  localparam logic [3:0] MF_LL = 4'd8;
  localparam logic [3:0] MF_DW = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Fields captured on accept so MEM may move on while a load is outstanding.
  logic              hold_mem_to_reg;
  logic              hold_reg_write;
  logic [REG_AW-1:0] hold_dest;
  logic [3:0]        hold_func;
  logic [DATA_W-1:0] hold_alu;
  logic [DATA_W-1:0] hold_rt;
  logic [ADDR_W-1:0] hold_addr;

  // Reservation address (word granularity).
  logic [ADDR_W-3:0] ll_addr;

  // Handshake / sequencing strobes.
  logic accept;
  logic need_wait;
  logic retire;

  // Fields of the instruction being resolved this cycle.
  logic              cur_mem_to_reg;
  logic              cur_reg_write;
  logic [REG_AW-1:0] cur_dest;
  logic [3:0]        cur_func;
  logic [DATA_W-1:0] cur_alu;
  logic [DATA_W-1:0] cur_rt;
  logic [ADDR_W-1:0] cur_addr;

  // Alignment datapath.
  logic [OW-1:0]        k;
  logic [OW-1:0]        k_half;
  logic [OW-1:0]        k_word;
  logic [DATA_W-1:0]    lane_b;
  logic [DATA_W-1:0]    lane_h;
  logic [DATA_W-1:0]    lane_w;
  logic signed [7:0]    byte_s;
  logic signed [15:0]   half_s;
  logic signed [31:0]   word_s;
  logic [DATA_W-1:0]    word_sx;
  logic [DATA_W-1:0]    wl_val;
  logic [DATA_W-1:0]    wr_val;
  logic                 is_sc;
  logic                 is_ll;
  logic                 sc_ok;
  logic [DATA_W-1:0]    result;

  // A memory-path op other than SC stalls when its data is not yet present.
  assign need_wait = MemtoReg & (Memfunc != MF_SC) & ~MemValid;

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: park in WAIT until the load data shows up.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (InValid && need_wait) state_next = WAIT;
      WAIT:    if (MemValid)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready, accept and retire strobes.
  always_comb begin
    InReady = 1'b0;
    accept  = 1'b0;
    retire  = 1'b0;
    case (state_reg)
      IDLE: begin
        InReady = 1'b1;
        accept  = InValid;
        retire  = InValid & ~need_wait;
      end
      WAIT: begin
        retire = MemValid;
      end
      default: begin
        InReady = 1'b0;
      end
    endcase
  end

  // Capture the instruction fields on accept.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      hold_mem_to_reg <= 1'b0;
      hold_reg_write  <= 1'b0;
      hold_dest       <= '0;
      hold_func       <= '0;
      hold_alu        <= '0;
      hold_rt         <= '0;
      hold_addr       <= '0;
    end else if (accept) begin
      hold_mem_to_reg <= MemtoReg;
      hold_reg_write  <= RegWrite;
      hold_dest       <= DestReg;
      hold_func       <= Memfunc;
      hold_alu        <= ALUData;
      hold_rt         <= RtData;
      hold_addr       <= MemAddr;
    end
  end

  // In IDLE the live fields are resolved directly; in WAIT the held copy is used.
  always_comb begin
    if (state_reg == WAIT) begin
      cur_mem_to_reg = hold_mem_to_reg;
      cur_reg_write  = hold_reg_write;
      cur_dest       = hold_dest;
      cur_func       = hold_func;
      cur_alu        = hold_alu;
      cur_rt         = hold_rt;
      cur_addr       = hold_addr;
    end else begin
      cur_mem_to_reg = MemtoReg;
      cur_reg_write  = RegWrite;
      cur_dest       = DestReg;
      cur_func       = Memfunc;
      cur_alu        = ALUData;
      cur_rt         = RtData;
      cur_addr       = MemAddr;
    end
  end

  // Lane extraction and unaligned merges (little-endian byte offset k).
  always_comb begin
    k      = cur_addr[OW-1:0];
    k_half = k & HALF_MASK;
    k_word = k & WORD_MASK;
    lane_b = MemData >> {k, 3'b000};
    lane_h = MemData >> {k_half, 3'b000};
    lane_w = MemData >> {k_word, 3'b000};
    byte_s = lane_b[7:0];
    half_s = lane_h[15:0];
    word_s = lane_w[31:0];
    word_sx = DATA_W'(word_s);
    // NB-1-k equals ~k over OW bits, so ~k gives the WL byte shift directly.
    wl_val = (MemData << {~k, 3'b000}) | (cur_rt & ~(ONES << {~k, 3'b000}));
    wr_val = (MemData >> {k, 3'b000})  | (cur_rt & ~(ONES >> {k, 3'b000}));
  end

  // SC is identified by its function code alone; LL also needs the memory path.
  assign is_sc = (cur_func == MF_SC);
  assign is_ll = cur_mem_to_reg & (cur_func == MF_LL);
  assign sc_ok = LLBit & (cur_addr[ADDR_W-1:2] == ll_addr);

  // Select the write-back value.
  always_comb begin
    result = word_sx;
    if (is_sc) begin
      result = sc_ok ? DATA_W'(1) : '0;
    end else if (!cur_mem_to_reg) begin
      result = cur_alu;
    end else begin
      case (cur_func)
        MF_BS:   result = DATA_W'(byte_s);
        MF_BU:   result = DATA_W'(lane_b[7:0]);
        MF_HS:   result = DATA_W'(half_s);
        MF_HU:   result = DATA_W'(lane_h[15:0]);
        MF_WL:   result = wl_val;
        MF_WR:   result = wr_val;
        MF_DW:   result = (DATA_W == 64) ? MemData : word_sx;
        default: result = word_sx;
      endcase
    end
  end

  // Registered write-back outputs; data and register index hold between retires.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      WBValid <= 1'b0;
      WBWrite <= 1'b0;
      WBReg   <= '0;
      WBData  <= '0;
    end else begin
      WBValid <= retire;
      WBWrite <= retire & cur_reg_write;
      if (retire) begin
        WBReg  <= cur_dest;
        WBData <= result;
      end
    end
  end

  // Reservation: Invalidate wins over an LL retiring in the same cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      LLBit   <= 1'b0;
      ll_addr <= '0;
    end else begin
      if (retire && is_ll) begin
        ll_addr <= cur_addr[ADDR_W-1:2];
      end
      if (Invalidate) begin
        LLBit <= 1'b0;
      end else if (retire && is_ll) begin
        LLBit <= 1'b1;
      end else if (retire && is_sc) begin
        LLBit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_mc.sv
// Directed bench for wb_stage_mc: one 32-bit and one 64-bit instance.
module tb_wb_stage_mc;

  logic clk;
  logic n_reset;

  // 32-bit instance signals.
  logic        in_valid, in_ready, mem_to_reg, reg_write, mem_valid, invalidate;
  logic [4:0]  dest_reg, wb_reg;
  logic [3:0]  mem_func;
  logic [31:0] alu_data, rt_data, mem_addr, mem_data, wb_data;
  logic        wb_valid, wb_write, ll_bit;

  // 64-bit instance signals.
  logic        b_in_valid, b_in_ready, b_mem_to_reg, b_reg_write, b_mem_valid, b_invalidate;
  logic [4:0]  b_dest_reg, b_wb_reg;
  logic [3:0]  b_mem_func;
  logic [63:0] b_alu_data, b_rt_data, b_mem_data, b_wb_data;
  logic [31:0] b_mem_addr;
  logic        b_wb_valid, b_wb_write, b_ll_bit;

  int n_cmp;
  int n_err;

  wb_stage_mc #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) u_dut32 (
    .Clock(clk), .nReset(n_reset),
    .InValid(in_valid), .InReady(in_ready),
    .MemtoReg(mem_to_reg), .RegWrite(reg_write), .DestReg(dest_reg),
    .Memfunc(mem_func), .ALUData(alu_data), .RtData(rt_data),
    .MemAddr(mem_addr), .MemData(mem_data), .MemValid(mem_valid),
    .Invalidate(invalidate),
    .WBValid(wb_valid), .WBWrite(wb_write), .WBReg(wb_reg),
    .WBData(wb_data), .LLBit(ll_bit)
  );

  wb_stage_mc #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) u_dut64 (
    .Clock(clk), .nReset(n_reset),
    .InValid(b_in_valid), .InReady(b_in_ready),
    .MemtoReg(b_mem_to_reg), .RegWrite(b_reg_write), .DestReg(b_dest_reg),
    .Memfunc(b_mem_func), .ALUData(b_alu_data), .RtData(b_rt_data),
    .MemAddr(b_mem_addr), .MemData(b_mem_data), .MemValid(b_mem_valid),
    .Invalidate(b_invalidate),
    .WBValid(b_wb_valid), .WBWrite(b_wb_write), .WBReg(b_wb_reg),
    .WBData(b_wb_data), .LLBit(b_ll_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "time limit reached");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 32-bit instruction presented for a single cycle.
  task automatic do_op(input logic mtr, input logic rw, input logic [3:0] func,
                       input logic [31:0] addr, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [31:0] mdata,
                       input logic mvalid);
    in_valid   = 1'b1;
    mem_to_reg = mtr;
    reg_write  = rw;
    mem_func   = func;
    mem_addr   = addr;
    alu_data   = alu;
    rt_data    = rt;
    mem_data   = mdata;
    mem_valid  = mvalid;
    step();
    in_valid   = 1'b0;
    mem_valid  = 1'b0;
  endtask

  // One 64-bit load presented with data already valid.
  task automatic do_op64(input logic [3:0] func, input logic [31:0] addr,
                         input logic [63:0] mdata);
    b_in_valid   = 1'b1;
    b_mem_to_reg = 1'b1;
    b_reg_write  = 1'b1;
    b_mem_func   = func;
    b_mem_addr   = addr;
    b_mem_data   = mdata;
    b_mem_valid  = 1'b1;
    step();
    b_in_valid   = 1'b0;
    b_mem_valid  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_reset = 1'b0;
    in_valid = 0; mem_to_reg = 0; reg_write = 0; mem_valid = 0; invalidate = 0;
    dest_reg = 0; mem_func = 4'd4; alu_data = 0; rt_data = 0; mem_addr = 0; mem_data = 0;
    b_in_valid = 0; b_mem_to_reg = 0; b_reg_write = 0; b_mem_valid = 0; b_invalidate = 0;
    b_dest_reg = 0; b_mem_func = 4'd4; b_alu_data = 0; b_rt_data = 0; b_mem_addr = 0; b_mem_data = 0;

    // Reset state.
    step();
    step();
    check_val("rst_wbvalid", {63'd0, wb_valid}, 64'd0);
    check_val("rst_wbdata", {32'd0, wb_data}, 64'd0);
    check_val("rst_llbit", {63'd0, ll_bit}, 64'd0);
    check_val("rst_inready", {63'd0, in_ready}, 64'd1);
    check_val("rst64_wbdata", b_wb_data, 64'd0);
    n_reset = 1'b1;
    step();

    // 1. ALU op.
    dest_reg = 5'd3;
    do_op(1'b0, 1'b1, 4'd4, 32'h0, 32'h0000_1234, 32'h0, 32'h0, 1'b0);
    check_val("alu_wbvalid", {63'd0, wb_valid}, 64'd1);
    check_val("alu_wbwrite", {63'd0, wb_write}, 64'd1);
    check_val("alu_wbreg", {59'd0, wb_reg}, 64'd3);
    check_val("alu_wbdata", {32'd0, wb_data}, 64'h0000_1234);
    step();
    check_val("idle_wbvalid", {63'd0, wb_valid}, 64'd0);
    check_val("idle_wbdata_hold", {32'd0, wb_data}, 64'h0000_1234);

    // RegWrite=0 still retires and updates data but does not write.
    dest_reg = 5'd4;
    do_op(1'b0, 1'b0, 4'd4, 32'h0, 32'h0000_0055, 32'h0, 32'h0, 1'b0);
    check_val("nowr_wbvalid", {63'd0, wb_valid}, 64'd1);
    check_val("nowr_wbwrite", {63'd0, wb_write}, 64'd0);
    check_val("nowr_wbdata", {32'd0, wb_data}, 64'h55);

    // 2. Byte load with three stall cycles; corrupt live fields to prove they are held.
    dest_reg = 5'd5;
    do_op(1'b1, 1'b1, 4'd0, 32'h0000_0102, 32'h0, 32'h0, 32'h80FF_7F00, 1'b0);
    mem_func = 4'hF;
    mem_addr = 32'h0;
    dest_reg = 5'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("wait%0d_inready", i), {63'd0, in_ready}, 64'd0);
      check_val($sformatf("wait%0d_wbvalid", i), {63'd0, wb_valid}, 64'd0);
      step();
    end
    in_valid = 1'b0;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    check_val("bs_wbvalid", {63'd0, wb_valid}, 64'd1);
    check_val("bs_wbreg", {59'd0, wb_reg}, 64'd5);
    check_val("bs_wbdata", {32'd0, wb_data}, 64'hFFFF_FFFF);
    check_val("bs_inready", {63'd0, in_ready}, 64'd1);
    step();
    check_val("bs_no_repeat", {63'd0, wb_valid}, 64'd0);

    do_op(1'b1, 1'b1, 4'd1, 32'h0000_0102, 32'h0, 32'h0, 32'h80FF_7F00, 1'b1);
    check_val("bu_wbdata", {32'd0, wb_data}, 64'h0000_00FF);
    do_op(1'b1, 1'b1, 4'd2, 32'h0000_0102, 32'h0, 32'h0, 32'h80FF_7F00, 1'b1);
    check_val("hs_wbdata", {32'd0, wb_data}, 64'hFFFF_80FF);
    do_op(1'b1, 1'b1, 4'd3, 32'h0000_0103, 32'h0, 32'h0, 32'h80FF_7F00, 1'b1);
    check_val("hu_odd_wbdata", {32'd0, wb_data}, 64'h0000_80FF);
    do_op(1'b1, 1'b1, 4'd9, 32'h0000_0100, 32'h0, 32'h0, 32'h8765_4321, 1'b1);
    check_val("dw32_wbdata", {32'd0, wb_data}, 64'h8765_4321);

    // 3. WL/WR merges.
    do_op(1'b1, 1'b1, 4'd5, 32'h0000_0201, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
    check_val("wl_k1", {32'd0, wb_data}, 64'h3344_CCDD);
    do_op(1'b1, 1'b1, 4'd6, 32'h0000_0201, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
    check_val("wr_k1", {32'd0, wb_data}, 64'hAA11_2233);
    do_op(1'b1, 1'b1, 4'd6, 32'h0000_0200, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
    check_val("wr_k0", {32'd0, wb_data}, 64'h1122_3344);
    do_op(1'b1, 1'b1, 4'd5, 32'h0000_0203, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
    check_val("wl_k3", {32'd0, wb_data}, 64'h1122_3344);

    // 4. LL/SC pairs.
    do_op(1'b1, 1'b1, 4'd8, 32'h0000_0040, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1);
    check_val("ll_wbdata", {32'd0, wb_data}, 64'hCAFE_F00D);
    check_val("ll_llbit", {63'd0, ll_bit}, 64'd1);
    do_op(1'b1, 1'b1, 4'd7, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 1'b0);
    check_val("sc_ok_wbvalid", {63'd0, wb_valid}, 64'd1);
    check_val("sc_ok_wbdata", {32'd0, wb_data}, 64'd1);
    check_val("sc_ok_llbit", {63'd0, ll_bit}, 64'd0);
    do_op(1'b1, 1'b1, 4'd7, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 1'b0);
    check_val("sc_again_wbdata", {32'd0, wb_data}, 64'd0);

    do_op(1'b1, 1'b1, 4'd8, 32'h0000_0040, 32'h0, 32'h0, 32'h1, 1'b1);
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    check_val("inv_llbit", {63'd0, ll_bit}, 64'd0);
    do_op(1'b1, 1'b1, 4'd7, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 1'b0);
    check_val("sc_inv_wbdata", {32'd0, wb_data}, 64'd0);

    do_op(1'b1, 1'b1, 4'd8, 32'h0000_0040, 32'h0, 32'h0, 32'h1, 1'b1);
    do_op(1'b1, 1'b1, 4'd7, 32'h0000_0044, 32'h0, 32'h0, 32'h0, 1'b0);
    check_val("sc_addr_wbdata", {32'd0, wb_data}, 64'd0);
    check_val("sc_addr_llbit", {63'd0, ll_bit}, 64'd0);

    do_op(1'b1, 1'b1, 4'd8, 32'h0000_0040, 32'h0, 32'h0, 32'h1, 1'b1);
    do_op(1'b1, 1'b1, 4'd7, 32'h0000_0043, 32'h0, 32'h0, 32'h0, 1'b0);
    check_val("sc_sameword_wbdata", {32'd0, wb_data}, 64'd1);

    invalidate = 1'b1;
    do_op(1'b1, 1'b1, 4'd8, 32'h0000_0040, 32'h0, 32'h0, 32'h1, 1'b1);
    invalidate = 1'b0;
    check_val("ll_inv_wbvalid", {63'd0, wb_valid}, 64'd1);
    check_val("ll_inv_llbit", {63'd0, ll_bit}, 64'd0);

    // 5. Reset while waiting on a load.
    do_op(1'b1, 1'b1, 4'd8, 32'h0000_0080, 32'h0, 32'h0, 32'h0000_0077, 1'b1);
    check_val("pre_rst_llbit", {63'd0, ll_bit}, 64'd1);
    dest_reg = 5'd7;
    do_op(1'b1, 1'b1, 4'd0, 32'h0000_0100, 32'h0, 32'h0, 32'h0000_0011, 1'b0);
    check_val("pre_rst_inready", {63'd0, in_ready}, 64'd0);
    n_reset = 1'b0;
    #1;
    check_val("midrst_wbvalid", {63'd0, wb_valid}, 64'd0);
    check_val("midrst_wbwrite", {63'd0, wb_write}, 64'd0);
    check_val("midrst_wbreg", {59'd0, wb_reg}, 64'd0);
    check_val("midrst_wbdata", {32'd0, wb_data}, 64'd0);
    check_val("midrst_llbit", {63'd0, ll_bit}, 64'd0);
    check_val("midrst_inready", {63'd0, in_ready}, 64'd1);
    step();
    n_reset = 1'b1;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    check_val("postrst_wbvalid", {63'd0, wb_valid}, 64'd0);
    check_val("postrst_inready", {63'd0, in_ready}, 64'd1);

    // 6. 64-bit datapath.
    do_op64(4'd2, 32'h0000_0006, 64'h8001_0000_0000_0000);
    check_val("d64_hs_k6", b_wb_data, 64'hFFFF_FFFF_FFFF_8001);
    do_op64(4'd9, 32'h0000_0000, 64'h0123_4567_89AB_CDEF);
    check_val("d64_dw", b_wb_data, 64'h0123_4567_89AB_CDEF);
    do_op64(4'd4, 32'h0000_0004, 64'h89AB_CDEF_0123_4567);
    check_val("d64_wd_k4", b_wb_data, 64'hFFFF_FFFF_89AB_CDEF);
    do_op64(4'd1, 32'h0000_0007, 64'h8001_0000_0000_0000);
    check_val("d64_bu_k7", b_wb_data, 64'h0000_0000_0000_0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_mc.md
Name: wb_stage_mc

Overview:
Parametrised write-back stage for the 5-stage core. It is the successor to the single-cycle WB mux. It adds the following:
- registered outputs
- a valid/ready handshake toward MEM
- multi-cycle load support (waits on MemValid)
- byte-offset load alignment for any data width
- proper LWL/LWR byte merging
- an LL/SC reservation register

It sits between the MEM pipeline register and the register-file write port.

Parameters:
DATA_W, 32, datapath width in bits; legal values 32 or 64.
ADDR_W, 32, memory address width.
REG_AW, 5, register index width.

Ports:
Clock  in  1  core clock, rising edge
nReset  in  1  asynchronous active-low reset
InValid  in  1  MEM stage presents an instruction
InReady  out  1  stage can accept; combinational, equals (state == IDLE)
MemtoReg  in  1  result comes from memory path (loads, LL)
RegWrite  in  1  instruction writes the register file
DestReg  in  REG_AW  destination register
Memfunc  in  4  0 BS, 1 BU, 2 HS, 3 HU, 4 WD, 5 WL, 6 WR, 7 SC, 8 LL, 9 DW; others decode as WD
ALUData  in  DATA_W  ALU result
RtData  in  DATA_W  old rt value (merge source)
MemAddr  in  ADDR_W  effective address
MemData  in  DATA_W  aligned memory word/doubleword
MemValid  in  1  MemData is valid this cycle
Invalidate  in  1  clears LL reservation (snoop/exception)
WBValid  out  1  one-cycle pulse per retired instruction
WBWrite  out  1  register-file write enable (WBValid & latched RegWrite)
WBReg  out  REG_AW  destination register
WBData  out  DATA_W  write-back data
LLBit  out  1  reservation valid

Behaviour:
- Reset (async, nReset=0):
  - state=IDLE; WBValid, WBWrite, WBReg, WBData, LLBit, LLAddr all 0.
  - Reset during WAIT aborts the instruction; no WBValid is produced.
- Accept: an instruction is accepted when InValid & InReady. All input fields except MemData/MemValid are captured into a hold register on accept.
- FSM:
  - IDLE→IDLE: accept of a non-memory op, SC, or memory op with MemValid=1 in the same cycle. Results are registered and WBValid=1 next cycle.
  - IDLE→WAIT: accept of MemtoReg=1 (not SC) with MemValid=0. InReady=0 while in WAIT.
  - WAIT→IDLE: first cycle MemValid=1. Result is computed from held fields plus live MemData; WBValid=1 next cycle.
  - InValid is ignored in WAIT. Upstream must hold its fields (standard stall).
- Latency: exactly 1 cycle after the accept/MemValid edge. Throughput is 1 per cycle when loads hit.
- Byte lane selection:
  - NB=DATA_W/8; k=MemAddr[log2(NB)-1:0], little-endian.
  - BS/BU: byte k, sign-/zero-extended to DATA_W.
  - HS/HU: halfword at k with bit0 ignored, extended.
  - WD: word at k[log2NB-1:2] (k=0 for 32-bit), sign-extended to DATA_W.
  - DW: full MemData; decodes as WD when DATA_W=32.
- Unaligned merges:
  - WL: (MemData << 8*(NB-1-k)) | (RtData & low (NB-1-k) bytes mask).
  - WR: (MemData >> 8*k) | (RtData & high k bytes mask).
  - k=NB-1 makes WL=MemData; k=0 makes WR=MemData.
- MemtoReg=0: WBData=ALUData.
- LL/SC:
  - LL: loads as WD. On retire, LLBit←1 and LLAddr←MemAddr[ADDR_W-1:2].
  - SC: does not wait on MemValid. WBData=1 if LLBit & (MemAddr[ADDR_W-1:2]==LLAddr), else 0. LLBit←0 on retire.
  - Invalidate clears LLBit in any cycle. It has priority over a simultaneous LL retire, so LLBit stays 0.
- WBWrite=0 when RegWrite=0, even if WBValid=1. WBData is still updated.
- With no retire, WBValid and WBWrite are 0. WBReg and WBData hold their last values.

Test Plan:
1. ALU op: InValid=1, MemtoReg=0, RegWrite=1, DestReg=3, ALUData=0x1234 → next cycle WBValid=1, WBWrite=1, WBReg=3, WBData=0x00001234.
2. Load byte, delayed memory:
   - Stimulus: BS, MemAddr=0x102, MemData=0x80FF7F00, MemValid low for 3 cycles.
   - Required: InReady=0 for 3 cycles, then WBData=0xFFFFFFFF one cycle after MemValid. BU with same data → 0x000000FF.
3. WL/WR merge, DATA_W=32, RtData=0xAABBCCDD, MemData=0x11223344:
   - WL k=1 → 0x3344CCDD.
   - WR k=1 → 0xAA112233.
   - WR k=0 → 0x11223344.
4. LL/SC pair:
   - LL @0x40, then SC @0x40 → SC WBData=1, LLBit 0 afterwards.
   - Repeat with Invalidate pulse between the two → WBData=0.
   - SC @0x44 after LL @0x40 → WBData=0.
5. Reset mid-WAIT: pull nReset low during WAIT → all outputs 0 immediately, no WBValid after release, InReady=1.
6. DATA_W=64:
   - HS k=6, MemData=0x8001_0000_0000_0000 → WBData=0xFFFF_FFFF_FFFF_8001.
   - DW returns MemData unchanged.
